cpu_sram_like_bridge: RTL

//   Sits between the CPU core's inst/data SRAM ports and one shared sram-like bus (req/addr_ok/data_ok).

---
 rtl/cpu_sram_like_bridge.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sram_like_bridge.sv
// cpu_sram_like_bridge
//   Connects the CPU core's instruction and data SRAM ports to a single
//   sram-like bus (req / addr_ok / data_ok). Only one bus transaction is
//   in flight at a time. Data accesses win over fetches. Returned read data
//   is kept in per-port buffers. i_stall / d_stall hold the pipeline until
//   every access requested in the current cycle has completed.
//
// Ports
//   clk, resetn                       clock, async active-low reset
//   inst_en/inst_addr/inst_rdata      CPU fetch port
//   data_en/data_wen/data_addr/
//   data_wdata/data_rdata             CPU load/store port (wen==0 means read)
//   i_stall, d_stall                  per-port "not yet complete"
//   req/wr/size/addr/wdata            bus request channel (registered)
//   addr_ok/data_ok/rdata             bus handshake and read data
//
// State     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no transaction in flight; picks the next port that stalls
// S_D_ADDR  | data request on the bus, waiting for addr_ok
// S_D_WAIT  | data address accepted, waiting for data_ok
// S_I_ADDR  | fetch request on the bus, waiting for addr_ok
// S_I_WAIT  | fetch address accepted, waiting for data_ok
module cpu_sram_like_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              i_stall,
    output logic              d_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_ADDR,
        S_D_WAIT,
        S_I_ADDR,
        S_I_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] ibuf_q, ibuf_d;
    logic [DATA_W-1:0] dbuf_q, dbuf_d;

    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic              i_fin;
    logic              d_fin;

    assign i_stall    = inst_en & ~i_done_q;
    assign d_stall    = data_en & ~d_done_q;
    assign inst_rdata = ibuf_q;
    assign data_rdata = dbuf_q;
    assign req        = req_q;
    assign wr         = wr_q;
    assign size       = size_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;

    // Byte enables select transfer size and the low address bits; any
    // enable pattern not listed goes out as a full word at the given address.
    always_comb begin
        d_wr   = |data_wen;
        d_size = 2'd2;
        d_addr = data_addr;
        case (data_wen)
            4'b0000: d_addr[1:0] = 2'b00;
            4'b0011: begin d_size = 2'd1; d_addr[1:0] = 2'b00; end
            4'b1100: begin d_size = 2'd1; d_addr[1:0] = 2'b10; end
            4'b0001: begin d_size = 2'd0; d_addr[1:0] = 2'b00; end
            4'b0010: begin d_size = 2'd0; d_addr[1:0] = 2'b01; end
            4'b0100: begin d_size = 2'd0; d_addr[1:0] = 2'b10; end
            4'b1000: begin d_size = 2'd0; d_addr[1:0] = 2'b11; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_done_d = i_done_q;
        d_done_d = d_done_q;
        ibuf_d   = ibuf_q;
        dbuf_d   = dbuf_q;
        i_fin    = 1'b0;
        d_fin    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_stall) begin
                    state_d = S_D_ADDR;
                    req_d   = 1'b1;
                    wr_d    = d_wr;
                    size_d  = d_size;
                    addr_d  = d_addr;
                    wdata_d = data_wdata;
                end else if (i_stall) begin
                    state_d = S_I_ADDR;
                    req_d   = 1'b1;
                    wr_d    = 1'b0;
                    size_d  = 2'd2;
                    addr_d  = inst_addr;
                end
            end
            // A slave may complete in the same cycle it accepts the address.
            S_D_ADDR: begin
                if (addr_ok) begin
                    req_d = 1'b0;
                    if (data_ok) begin
                        d_fin   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_D_WAIT;
                    end
                end
            end
            S_D_WAIT: begin
                if (data_ok) begin
                    d_fin   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_I_ADDR: begin
                if (addr_ok) begin
                    req_d = 1'b0;
                    if (data_ok) begin
                        i_fin   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_I_WAIT;
                    end
                end
            end
            S_I_WAIT: begin
                if (data_ok) begin
                    i_fin   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (d_fin) begin
            d_done_d = 1'b1;
            if (!wr_q) begin
                dbuf_d = rdata;
            end
        end
        if (i_fin) begin
            i_done_d = 1'b1;
            ibuf_d   = rdata;
        end

        // Pipeline advances only when neither port stalls; until then a
        // finished port keeps its done flag so it is not re-issued.
        if (!i_stall && !d_stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            ibuf_q   <= '0;
            dbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            ibuf_q   <= ibuf_d;
            dbuf_q   <= dbuf_d;
        end
    end

endmodule
